// File: rtl/trail_buffer.sv
// rtl/trail_buffer.sv - pixel pass-through that keeps a fixed-length trail and erases its tail
module trail_buffer #(
  parameter int X_W       = 7,
  parameter int Y_W       = 7,
  parameter int C_W       = 3,
  parameter int DEPTH     = 16,
  parameter int TRAIL_LEN = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [X_W-1:0]           in_x,
  input  logic [Y_W-1:0]           in_y,
  input  logic [C_W-1:0]           in_color,
  input  logic                     in_we,
  input  logic                     flush,
  output logic [X_W-1:0]           out_x,
  output logic [Y_W-1:0]           out_y,
  output logic [C_W-1:0]           out_color,
  output logic                     out_we,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     collision,
  output logic                     overflow,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int XY_W  = X_W + Y_W;

  logic [XY_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [XY_W-1:0]  in_xy;
  logic [PTR_W-1:0] offs;
  logic             push_req;
  logic             full;
  logic             do_push;
  logic             erase;
  logic             hit;

  assign in_xy = {in_x, in_y};

  always_comb begin
    push_req = in_we && (in_color != '0);
    full     = (occupancy == OCC_W'(DEPTH));
    do_push  = push_req && !full;
    // in_we owns the output port, so erases only drain on idle cycles
    erase    = !in_we && ((occupancy > OCC_W'(TRAIL_LEN)) ||
                          (busy && (occupancy != '0)));
  end

  // An entry is live when its distance from the tail is below occupancy
  always_comb begin
    hit  = 1'b0;
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - tail;
      if (({1'b0, offs} < occupancy) && (mem[i] == in_xy)) hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[head] <= in_xy;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      out_x     <= '0;
      out_y     <= '0;
      out_color <= '0;
      out_we    <= 1'b0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      collision <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_we <= 1'b0;
      if (in_we) begin
        out_x     <= in_x;
        out_y     <= in_y;
        out_color <= in_color;
        out_we    <= 1'b1;
      end else if (erase) begin
        {out_x, out_y} <= mem[tail];
        out_color      <= '0;
        out_we         <= 1'b1;
      end

      if (do_push) begin
        head      <= head + PTR_W'(1);
        occupancy <= occupancy + OCC_W'(1);
      end else if (erase) begin
        tail      <= tail + PTR_W'(1);
        occupancy <= occupancy - OCC_W'(1);
      end

      if (flush && !busy) begin
        busy      <= 1'b1;
        collision <= 1'b0;
        overflow  <= 1'b0;
      end else if (busy && (occupancy == '0) && !do_push) begin
        busy <= 1'b0;
      end

      if (push_req && hit)  collision <= 1'b1;
      if (push_req && full) overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trail_buffer.sv
// tb/tb_trail_buffer.sv - scoreboard bench for trail_buffer
module tb_trail_buffer;

  typedef struct {
    logic [6:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] in_x = '0;
  logic [6:0] in_y = '0;
  logic [2:0] in_color = '0;
  logic       in_we = 1'b0;
  logic       flush = 1'b0;

  logic [6:0] a_out_x, a_out_y, b_out_x, b_out_y;
  logic [2:0] a_out_color, b_out_color;
  logic       a_out_we, a_collision, a_overflow, a_busy;
  logic       b_out_we, b_collision, b_overflow, b_busy;
  logic [4:0] a_occ;
  logic [2:0] b_occ;

  int n_checks = 0;
  int n_err    = 0;

  wr_t         exp_q[$];
  logic [13:0] trail_q[$];
  bit          m_busy = 0;

  trail_buffer #(.X_W(7), .Y_W(7), .C_W(3), .DEPTH(16), .TRAIL_LEN(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_x(in_x), .in_y(in_y), .in_color(in_color),
    .in_we(in_we), .flush(flush), .out_x(a_out_x), .out_y(a_out_y),
    .out_color(a_out_color), .out_we(a_out_we), .occupancy(a_occ),
    .collision(a_collision), .overflow(a_overflow), .busy(a_busy)
  );

  trail_buffer #(.X_W(7), .Y_W(7), .C_W(3), .DEPTH(4), .TRAIL_LEN(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_x(in_x), .in_y(in_y), .in_color(in_color),
    .in_we(in_we), .flush(flush), .out_x(b_out_x), .out_y(b_out_y),
    .out_color(b_out_color), .out_we(b_out_we), .occupancy(b_occ),
    .collision(b_collision), .overflow(b_overflow), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference behaviour of the DEPTH=16 / TRAIL_LEN=4 instance, evaluated on pre-edge state
  task automatic step(input logic we, input logic [6:0] x, input logic [6:0] y,
                      input logic [2:0] c, input logic fl);
    int   sz;
    bit   pushing;
    wr_t  w;
    logic [13:0] e;
    in_we = we; in_x = x; in_y = y; in_color = c; flush = fl;
    sz = trail_q.size();
    pushing = we && (c != 0) && (sz < 16);
    if (we) begin
      w.x = x; w.y = y; w.c = c;
      exp_q.push_back(w);
      if (pushing) trail_q.push_back({x, y});
    end else if (sz > 4 || (m_busy && sz > 0)) begin
      e = trail_q.pop_front();
      w.x = e[13:7]; w.y = e[6:0]; w.c = 3'd0;
      exp_q.push_back(w);
    end
    if (fl && !m_busy) m_busy = 1;
    else if (m_busy && sz == 0 && !pushing) m_busy = 0;

    @(posedge clk); #1;
    in_we = 1'b0; flush = 1'b0;
    if (a_out_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        w = exp_q.pop_front();
        check("out_x", a_out_x, w.x);
        check("out_y", a_out_y, w.y);
        check("out_color", a_out_color, w.c);
      end
    end else if (exp_q.size() != 0) begin
      check("missing_we", 0, 1);
      void'(exp_q.pop_front());
    end
    check("occupancy", a_occ, trail_q.size());
    check("busy", a_busy, m_busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 7'd0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b1; in_we = 1'b1; flush = 1'b1;
    in_x = 7'h55; in_y = 7'h2a; in_color = 3'd5;
    @(posedge clk); #1;
    check("rst_out_x", a_out_x, 0);
    check("rst_out_y", a_out_y, 0);
    check("rst_out_color", a_out_color, 0);
    check("rst_out_we", a_out_we, 0);
    check("rst_occ", a_occ, 0);
    check("rst_collision", a_collision, 0);
    check("rst_overflow", a_overflow, 0);
    check("rst_busy", a_busy, 0);
    check("rst_b_occ", b_occ, 0);
    check("rst_b_out_we", b_out_we, 0);
    reset_n = 1'b0; in_we = 1'b0; flush = 1'b0;
    exp_q.delete();
    trail_q.delete();
    m_busy = 0;
  endtask

  initial begin
    // Trail of 4 with an idle gap after each push
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 7'(i), 7'd1, 3'b010, 1'b0);
      idle(1);
    end
    check("t1_erase_x", a_out_x, 1);
    check("t1_erase_color", a_out_color, 0);
    check("t1_occ", a_occ, 4);

    // Back-to-back burst builds a backlog that drains on idle cycles
    do_reset();
    for (int i = 1; i <= 7; i++) step(1'b1, 7'(i), 7'd1, 3'b001, 1'b0);
    check("t2_occ_burst", a_occ, 7);
    idle(3);
    check("t2_last_erase_x", a_out_x, 3);
    check("t2_occ_drained", a_occ, 4);
    idle(2);

    // Self-collision, sticky through idle
    do_reset();
    step(1'b1, 7'd10, 7'd10, 3'd4, 1'b0); idle(1);
    step(1'b1, 7'd11, 7'd10, 3'd4, 1'b0);
    check("t3_no_collision", a_collision, 0);
    idle(1);
    step(1'b1, 7'd10, 7'd10, 3'd4, 1'b0);
    check("t3_collision", a_collision, 1);
    idle(20);
    check("t3_collision_held", a_collision, 1);

    // Color-0 write is forwarded only
    do_reset();
    step(1'b1, 7'd5, 7'd5, 3'd0, 1'b0);
    check("t4_occ", a_occ, 0);
    check("t4_collision", a_collision, 0);
    step(1'b1, 7'd5, 7'd5, 3'd0, 1'b0);
    check("t4_collision_repeat", a_collision, 0);
    idle(1);

    // Overflow on the DEPTH=4 instance
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 7'(30 + i), 7'd2, 3'd1, 1'b0);
    check("t5_b_occ_full", b_occ, 4);
    check("t5_b_no_overflow", b_overflow, 0);
    step(1'b1, 7'd34, 7'd2, 3'd1, 1'b0);
    check("t5_b_overflow", b_overflow, 1);
    check("t5_b_fwd_we", b_out_we, 1);
    check("t5_b_fwd_x", b_out_x, 34);
    check("t5_b_occ", b_occ, 4);
    check("t5_a_overflow", a_overflow, 0);
    idle(2);

    // Flush with three entries, collision set beforehand
    do_reset();
    step(1'b1, 7'd20, 7'd5, 3'd2, 1'b0); idle(1);
    step(1'b1, 7'd21, 7'd5, 3'd2, 1'b0); idle(1);
    step(1'b1, 7'd20, 7'd5, 3'd2, 1'b0); idle(1);
    check("t6_collision_pre", a_collision, 1);
    step(1'b0, 7'd0, 7'd0, 3'd0, 1'b1);
    check("t6_busy", a_busy, 1);
    check("t6_collision_clr", a_collision, 0);
    idle(1);
    check("t6_erase1_x", a_out_x, 20);
    idle(1);
    check("t6_erase2_x", a_out_x, 21);
    idle(1);
    check("t6_erase3_we", a_out_we, 1);
    check("t6_busy_at_last", a_busy, 1);
    idle(1);
    check("t6_busy_done", a_busy, 0);
    check("t6_occ", a_occ, 0);
    idle(2);

    // Flush abandoned by reset after the first erase
    do_reset();
    step(1'b1, 7'd40, 7'd8, 3'd3, 1'b0);
    step(1'b1, 7'd41, 7'd8, 3'd3, 1'b0);
    step(1'b1, 7'd42, 7'd8, 3'd3, 1'b0);
    step(1'b0, 7'd0, 7'd0, 3'd0, 1'b1);
    idle(1);
    check("t7_erase1_x", a_out_x, 40);
    do_reset();
    idle(5);
    check("t7_busy", a_busy, 0);
    check("t7_out_we", a_out_we, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/trail_buffer.md
# trail_buffer

Downstream stage between the pixel-stepping datapath and the VGA adapter. Consumes the datapath's pixel write stream (x, y, color, write enable), forwards every write to the adapter, and remembers the last TRAIL_LEN coloured head positions so the moving dot leaves a fixed-length trail. Emits black erase writes for positions that fall off the trail's tail. Flags self-collision when the head lands on a pixel still in the trail.

## Interface
- X_W, 7: x coordinate width
- Y_W, 7: y coordinate width
- C_W, 3: color width
- DEPTH, 16: storage entries; power of two
- TRAIL_LEN, 12: visible trail length; 1 ≤ TRAIL_LEN ≤ DEPTH-2

- clk  in  1  single clock; all state on posedge
- reset_n  in  1  synchronous, active-high reset (1 = reset, despite the suffix)
- in_x  in  X_W  pixel x from datapath
- in_y  in  Y_W  pixel y from datapath
- in_color  in  C_W  pixel color from datapath
- in_we  in  1  pixel write strobe from datapath
- flush  in  1  single-cycle pulse: erase the whole trail
- out_x  out  X_W  pixel x to VGA adapter
- out_y  out  Y_W  pixel y to VGA adapter
- out_color  out  C_W  pixel color to VGA adapter
- out_we  out  1  write strobe to VGA adapter
- occupancy  out  log2(DEPTH)+1  stored entry count
- collision  out  1  sticky: head hit a stored trail pixel
- overflow  out  1  sticky: push dropped because storage was full
- busy  out  1  flush in progress

## Operation
- Storage: DEPTH-entry circular FIFO of {x, y} in flops (not RAM), with head/tail pointers and an occupancy counter. Pointers wrap modulo DEPTH.
- Pass-through: each in_we cycle registers {in_x, in_y, in_color} onto out_* with out_we = 1. in_we always wins the output port.
- Push: an in_we with in_color ≠ 0 pushes {in_x, in_y} at the head.
  - If occupancy == DEPTH, the push is dropped and overflow is set. The pixel is still forwarded.
  - in_color == 0 writes (the datapath's clear writes) are forwarded only, never stored.
- Collision: on a push, compare {in_x, in_y} against every valid entry before the push.
  - Any match sets collision one cycle later. collision is sticky.
- Erase: in a cycle with in_we = 0, if occupancy > TRAIL_LEN, or busy and occupancy > 0:
  - Next cycle, emit the tail entry with out_color = 0 and out_we = 1.
  - Pop the tail in the same cycle.
  - Erases are oldest-first, at most one per cycle. Backlog accumulates during back-to-back in_we and drains on idle cycles.
- Flush: a flush pulse sets busy and clears collision and overflow.
  - busy stays high until occupancy reaches 0; it drops the cycle after the final erase.
  - Pushes during busy are still stored and therefore also erased.
  - flush while busy is a no-op.
- Simultaneous in_we and pending erase: pass-through and push happen; the erase waits.
  - A push and a pop never occur in the same cycle.

## Timing
- Reset (reset_n = 1 at a clk edge): the following are all 0 the next cycle.
  - out_x, out_y, out_color, out_we
  - occupancy, both pointers
  - collision, overflow, busy
  - Stored data is don't-care.
- Reset mid-flush or mid-erase abandons all pending erases; no further out_we until a new in_we.
- Pass-through latency: 1 cycle from in_we to out_we.
- Erase latency: 1 cycle from the qualifying idle cycle.
- out_we is a single-cycle pulse per write. It is 0 in any cycle with neither a pass-through nor an erase; out_x, out_y and out_color hold their last value then.
- occupancy updates on the same edge as the push or pop.
- collision and overflow rise on the edge after the offending in_we.
- Widths: occupancy counts 0..DEPTH inclusive; coordinate compare uses the full X_W + Y_W bits.

## Test plan
- Reset with in_we = 1 and flush = 1 held: all outputs 0 after the edge, occupancy 0.
- TRAIL_LEN = 4: push (1,1),(2,1),(3,1),(4,1),(5,1) color 3'b010, each followed by an idle cycle.
  - Required: five pass-throughs, then one erase of (1,1) color 0; occupancy 4.
- TRAIL_LEN = 4: push (1,1) through (7,1) back-to-back, then idle.
  - Required: no erase during the burst.
  - Then erases (1,1),(2,1),(3,1) on consecutive cycles; occupancy 7→4.
- Push (10,10),(11,10),(10,10) with gaps.
  - Required: collision = 0 after the second, 1 after the third, held through 20 idle cycles.
- in_we with color 0 at (5,5): forwarded with out_color 0, occupancy unchanged, no collision.
  - DEPTH = 4, TRAIL_LEN = 2: five back-to-back pushes; the fifth sets overflow and is forwarded but not stored.
- Flush with 3 entries: busy = 1, three erases oldest-first, busy = 0 the cycle after the third, collision cleared.
  - Repeat with reset_n = 1 after the first erase: no further out_we, busy = 0.
